// File: rtl/abacus_axil_reader.sv
// AXI4-Lite master for the ABACUS profiler: reads runs of consecutive 32-bit
// registers onto a valid/ready stream, or performs a single register write.
module abacus_axil_reader #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [31:0]       o_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              o_last
);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_PUSH, S_AW_W, S_B, S_FIN
  } state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [CNT_W-1:0]    r_rem;
  logic [31:0]         r_odata;
  logic [ADDR_W-1:0]   r_oaddr;
  logic                r_err;
  logic                r_aw_done, r_w_done;
  logic                w_aw_hs, w_w_hs;

  assign w_aw_hs = (r_state == S_AW_W) && !r_aw_done && m_awready;
  assign w_w_hs  = (r_state == S_AW_W) && !r_w_done  && m_wready;

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        // A write wins over a simultaneous read start; the start is dropped.
        if (cmd_write)      w_next = S_AW_W;
        else if (cmd_start) w_next = (word_count != '0) ? S_AR : S_FIN;
      end
      S_AR:   if (m_arready) w_next = S_R;
      S_R:    if (m_rvalid)  w_next = S_PUSH;
      S_PUSH: if (o_ready)   w_next = (r_rem == CNT_W'(1)) ? S_FIN : S_AR;
      S_AW_W: if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = S_B;
      S_B:    if (m_bvalid)  w_next = S_FIN;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_FIN);
    m_arvalid = (r_state == S_AR);
    m_rready  = (r_state == S_R);
    o_valid   = (r_state == S_PUSH);
    o_last    = (r_state == S_PUSH) && (r_rem == CNT_W'(1));
    m_awvalid = (r_state == S_AW_W) && !r_aw_done;
    m_wvalid  = (r_state == S_AW_W) && !r_w_done;
    m_bready  = (r_state == S_B);
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rem     <= '0;
      r_odata   <= '0;
      r_oaddr   <= '0;
      r_err     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_write) begin
            r_addr    <= wr_addr;
            r_wdata   <= wr_data;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else if (cmd_start) begin
            r_addr <= start_addr;
            r_rem  <= word_count;
            r_err  <= 1'b0;
          end
        end
        S_R: if (m_rvalid) begin
          // Data is forwarded even on an error response; err just records it.
          r_odata <= m_rdata;
          r_oaddr <= r_addr;
          if (m_rresp != 2'b00) r_err <= 1'b1;
        end
        S_PUSH: if (o_ready) begin
          r_rem  <= r_rem - CNT_W'(1);
          r_addr <= r_addr + ADDR_W'(4);
        end
        S_AW_W: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
        S_B: if (m_bvalid && (m_bresp != 2'b00)) r_err <= 1'b1;
        default: ;
      endcase
    end
  end

  assign err      = r_err;
  assign m_araddr = r_addr;
  assign m_awaddr = r_addr;
  assign m_wdata  = r_wdata;
  assign m_wstrb  = 4'hF;
  assign o_data   = r_odata;
  assign o_addr   = r_oaddr;

endmodule

// File: tb/tb_abacus_axil_reader.sv
// Directed bench for abacus_axil_reader with a small AXI-Lite slave model
// and a stream collector.
module tb_abacus_axil_reader;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 6;

  logic aclk, rst;
  logic cmd_start, cmd_write;
  logic [ADDR_W-1:0] start_addr, wr_addr;
  logic [CNT_W-1:0] word_count;
  logic [31:0] wr_data;
  logic busy, done, err;
  logic [ADDR_W-1:0] m_araddr, m_awaddr, o_addr;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_rdata, m_wdata, o_data;
  logic [1:0] m_rresp, m_bresp;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [3:0] m_wstrb;
  logic o_valid, o_ready, o_last;

  abacus_axil_reader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .aclk(aclk), .rst(rst),
    .cmd_start(cmd_start), .start_addr(start_addr), .word_count(word_count),
    .cmd_write(cmd_write), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .o_data(o_data), .o_addr(o_addr), .o_valid(o_valid), .o_ready(o_ready),
    .o_last(o_last)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Slave model knobs and state
  logic        r_hold, aw_rdy, w_rdy;
  logic [31:0] bad_addr;
  logic        s_rvalid, s_bvalid, s_awseen, s_wseen;
  logic [31:0] s_rdata, s_awaddr, s_wdata;
  logic [1:0]  s_rresp;
  logic [3:0]  s_wstrb;
  int ar_cnt, aw_cnt, w_cnt, done_cnt;
  logic [31:0] got_d[$], got_a[$];
  bit          got_l[$];

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  assign m_arready = 1'b1;
  assign m_rvalid  = s_rvalid && !r_hold;
  assign m_rdata   = s_rdata;
  assign m_rresp   = s_rresp;
  assign m_awready = aw_rdy;
  assign m_wready  = w_rdy;
  assign m_bvalid  = s_bvalid;
  assign m_bresp   = 2'b00;

  always @(posedge aclk or posedge rst) begin
    if (rst) begin
      s_rvalid <= 1'b0; s_bvalid <= 1'b0; s_awseen <= 1'b0; s_wseen <= 1'b0;
    end else begin
      if (m_arvalid && m_arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= rd_val(m_araddr);
        s_rresp  <= (m_araddr == bad_addr) ? 2'b10 : 2'b00;
        ar_cnt   <= ar_cnt + 1;
      end else if (m_rvalid && m_rready) s_rvalid <= 1'b0;
      if (m_awvalid && m_awready) begin
        s_awseen <= 1'b1; s_awaddr <= m_awaddr; aw_cnt <= aw_cnt + 1;
      end
      if (m_wvalid && m_wready) begin
        s_wseen <= 1'b1; s_wdata <= m_wdata; s_wstrb <= m_wstrb; w_cnt <= w_cnt + 1;
      end
      if ((s_awseen || (m_awvalid && m_awready)) && (s_wseen || (m_wvalid && m_wready))
          && !s_bvalid) begin
        s_bvalid <= 1'b1; s_awseen <= 1'b0; s_wseen <= 1'b0;
      end else if (s_bvalid && m_bready) s_bvalid <= 1'b0;
      if (done) done_cnt <= done_cnt + 1;
      if (o_valid && o_ready) begin
        got_d.push_back(o_data); got_a.push_back(o_addr); got_l.push_back(o_last);
      end
    end
  end

  int n_cmp, n_bad;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic start_rd(input logic [31:0] a, input int n);
    @(negedge aclk);
    start_addr = a; word_count = CNT_W'(n); cmd_start = 1'b1;
    @(negedge aclk);
    cmd_start = 1'b0;
  endtask

  task automatic issue_wr(input logic [31:0] a, input logic [31:0] d, input bit also_start);
    @(negedge aclk);
    wr_addr = a; wr_data = d; cmd_write = 1'b1; cmd_start = also_start;
    start_addr = 32'hF003_0700; word_count = 6'd1;
    @(negedge aclk);
    cmd_write = 1'b0; cmd_start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 60) begin
      @(negedge aclk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    @(negedge aclk);
  endtask

  int cyc, ar0, aw0, w0, dn0, base;
  logic [31:0] d0;
  bit stable;

  initial begin
    n_cmp = 0; n_bad = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; done_cnt = 0;
    cmd_start = 0; cmd_write = 0; start_addr = 0; word_count = 0; wr_addr = 0; wr_data = 0;
    r_hold = 0; aw_rdy = 1; w_rdy = 1; bad_addr = 32'h0000_0001; o_ready = 1;
    s_rdata = 0; s_rresp = 0; s_awaddr = 0; s_wdata = 0; s_wstrb = 0;
    rst = 1;
    repeat (3) @(negedge aclk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_valids", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, o_valid, o_last}, 0);
    chk("rst_addr_data", {m_araddr, o_data}, 0);
    rst = 0;

    // Three-word run, zero-wait slave
    ar0 = ar_cnt; dn0 = done_cnt; base = got_d.size();
    start_rd(32'hF003_0100, 3);
    chk("run3_busy", busy, 1);
    wait_done(cyc);
    chk("run3_latency", cyc, 9);
    chk("run3_words", got_d.size() - base, 3);
    chk("run3_addr0", got_a[base], 32'hF003_0100);
    chk("run3_addr2", got_a[base+2], 32'hF003_0108);
    chk("run3_data1", got_d[base+1], rd_val(32'hF003_0104));
    chk("run3_last", {got_l[base], got_l[base+1], got_l[base+2]}, 3'b001);
    chk("run3_ar", ar_cnt - ar0, 3);
    chk("run3_done", done_cnt - dn0, 1);
    chk("run3_idle", {busy, err}, 2'b00);

    // Backpressure on the first word of a two-word run
    ar0 = ar_cnt; base = got_d.size(); o_ready = 0;
    start_rd(32'hF003_0200, 2);
    cyc = 0;
    while (!o_valid && cyc < 20) begin @(negedge aclk); cyc++; end
    chk("bp_valid", o_valid, 1);
    d0 = o_data; stable = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      if (!o_valid || o_data !== d0 || o_addr !== 32'hF003_0200) stable = 0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_data", d0, rd_val(32'hF003_0200));
    chk("bp_one_ar", ar_cnt - ar0, 1);
    o_ready = 1;
    wait_done(cyc);
    chk("bp_words", got_d.size() - base, 2);
    chk("bp_addr1", got_a[base+1], 32'hF003_0204);

    // Write with AW accepted two cycles ahead of W
    aw0 = aw_cnt; w0 = w_cnt; dn0 = done_cnt; aw_rdy = 1; w_rdy = 0;
    issue_wr(32'hF003_0004, 32'h0000_0001, 0);
    repeat (2) @(negedge aclk);
    chk("wr_aw_first", {aw_cnt - aw0, w_cnt - w0}, {32'd1, 32'd0});
    w_rdy = 1;
    wait_done(cyc);
    chk("wr_hs", {aw_cnt - aw0, w_cnt - w0}, {32'd1, 32'd1});
    chk("wr_payload", {s_awaddr, s_wdata, s_wstrb}, {32'hF003_0004, 32'h1, 4'hF});
    chk("wr_done_err", {done_cnt - dn0, 31'(err)}, {32'd1, 31'd0});

    // Error response on word 2 of 3
    base = got_d.size(); bad_addr = 32'hF003_0304;
    start_rd(32'hF003_0300, 3);
    wait_done(cyc);
    chk("rerr_words", got_d.size() - base, 3);
    chk("rerr_data1", got_d[base+1], rd_val(32'hF003_0304));
    chk("rerr_err", err, 1);
    bad_addr = 32'h0000_0001;
    start_rd(32'hF003_0400, 1);
    chk("rerr_cleared", err, 0);
    wait_done(cyc);
    chk("rerr_still_clear", err, 0);

    // Simultaneous start and write: only the write runs
    ar0 = ar_cnt; aw0 = aw_cnt;
    issue_wr(32'hF003_0008, 32'h0000_0002, 1);
    wait_done(cyc);
    chk("both_ar", ar_cnt - ar0, 0);
    chk("both_aw", aw_cnt - aw0, 1);
    chk("both_wdata", s_wdata, 32'h2);

    // Zero-length run
    ar0 = ar_cnt; dn0 = done_cnt;
    start_rd(32'hF003_0500, 0);
    wait_done(cyc);
    chk("zero_latency", cyc, 0);
    chk("zero_no_ar", ar_cnt - ar0, 0);
    chk("zero_done", done_cnt - dn0, 1);

    // Address wrap
    base = got_d.size();
    start_rd(32'hFFFF_FFFC, 2);
    wait_done(cyc);
    chk("wrap_addr", {got_a[base], got_a[base+1]}, {32'hFFFF_FFFC, 32'h0});

    // Reset while waiting for R data
    dn0 = done_cnt; r_hold = 1;
    start_rd(32'hF003_0600, 2);
    repeat (3) @(negedge aclk);
    chk("hold_in_r", m_rready, 1);
    rst = 1;
    #1;
    chk("mid_rst_ctrl", {busy, done, err, m_arvalid, m_rready, o_valid, o_last}, 0);
    chk("mid_rst_addr", {m_araddr, o_addr, o_data}, 0);
    repeat (2) @(negedge aclk);
    rst = 0; r_hold = 0;
    chk("mid_rst_no_done", done_cnt - dn0, 0);
    base = got_d.size();
    start_rd(32'hF003_0800, 1);
    wait_done(cyc);
    chk("post_rst_word", {got_a[base], got_d[base]}, {32'hF003_0800, rd_val(32'hF003_0800)});
    chk("post_rst_done", done_cnt - dn0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
